spi_master_seq: RTL and testbench
=================================

SPI_MASTER_SEQ -- requirements
Module: spi_master_seq

Interface
REQ-001: Parameter GAP_CYC, default 2: SS_n-high cycles between frames and after a transaction; legal range 1..15.
REQ-002: Parameter TURN_CYC, default 2: cycles between the last read-data command bit and the first MISO sample; legal range 0..15.
REQ-003: clk  input  1  single clock; all state changes on posedge clk.
REQ-004: rst  input  1  reset; asynchronous, active-high.
REQ-005: req_valid  input  1  host request valid.
REQ-006: req_rw  input  1  0 = memory write, 1 = memory read.
REQ-007: req_addr  input  8  memory address.
REQ-008: req_wdata  input  8  write data; ignored for reads.
REQ-009: req_ready  output  1  high only in IDLE; a request is accepted on a posedge with req_valid & req_ready.
REQ-010: done  output  1  one-cycle pulse at transaction completion.
REQ-011: rd_valid  output  1  one-cycle pulse, coincident with done, reads only.
REQ-012: rd_data  output  8  captured read byte; holds its value until the next read completes.
REQ-013: SS_n  output  1  slave select, active low.
REQ-014: MOSI  output  1  serial data to the slave.
REQ-015: MISO  input  1  serial data from the slave.

Function
REQ-016: The block SHALL register req_addr, req_wdata and req_rw on acceptance; input changes after acceptance SHALL have no effect.
REQ-017: Frame format SHALL be 11 bits, one bit per clk with SS_n low: bit0 = cmd[1], bit1 = cmd[0], bit2 = cmd[1], bits3..10 = payload LSB first.
REQ-018: cmd encoding SHALL be: 00 = write-address, 01 = write-data, 10 = read-address, 11 = read-data.
REQ-019: A write SHALL send frame {00, addr}, then GAP_CYC cycles with SS_n high, then frame {01, wdata}.
REQ-020: A read SHALL send frame {10, addr}, then GAP_CYC cycles with SS_n high, then frame {11, 0x00}.
REQ-021: During a read, SS_n SHALL stay low after frame {11, 0x00} for TURN_CYC cycles, then for 8 cycles while MISO is sampled on posedge, LSB first, into rd_data[0..7].
REQ-022: MOSI and SS_n SHALL be registered outputs; MOSI SHALL be 0 whenever SS_n is high or during turnaround and capture.
REQ-023: States SHALL be IDLE, SHIFT1, GAP1, SHIFT2, TURN, CAPTURE, GAP2. Transitions:
- IDLE -> SHIFT1 on acceptance.
- SHIFT1 -> GAP1 after 11 bits.
- GAP1 -> SHIFT2 after GAP_CYC cycles.
- SHIFT2 -> GAP2 (write) or TURN (read) after 11 bits.
- TURN -> CAPTURE after TURN_CYC cycles; TURN is skipped when TURN_CYC = 0.
- CAPTURE -> GAP2 after 8 bits.
- GAP2 -> IDLE after GAP_CYC cycles.
REQ-024: Timing: with acceptance at posedge 0, bit0 of frame 1 SHALL appear on MOSI with SS_n low in cycle 1.
REQ-025: done (and rd_valid for reads) SHALL pulse in the first GAP2 cycle, and rd_data SHALL be updated in that same cycle.
REQ-026: req_valid while req_ready is low SHALL be ignored; no queuing.
REQ-027: Back-to-back requests SHALL be separated by at least GAP_CYC SS_n-high cycles, guaranteed by GAP2.
REQ-028: The bit counter SHALL be 4 bits and the gap/turn counter 4 bits; counters SHALL reset to 0 on every state entry.

Reset
REQ-029: While rst is high, the block SHALL hold state IDLE, SS_n = 1, MOSI = 0, req_ready = 0, done = 0, rd_valid = 0, rd_data = 0x00, and all counters = 0.
REQ-030: rst asserted mid-transaction SHALL force SS_n high immediately (asynchronously) and abort the transaction with no done pulse.
REQ-031: req_ready SHALL rise on the first posedge after rst deasserts.

Verification
REQ-032: Write addr 0x5A, data 0xC3, GAP = 2 -> MOSI, cycles 1-11, = 0,0,0,0,1,0,1,1,0,1,0; SS_n high in cycles 12-13; frame 2 in cycles 14-24 = 0,1,0,1,1,0,0,0,0,1,1; done in cycle 25; req_ready in cycle 27.
REQ-033: Read addr 0x0F, TURN = 2, slave drives 0xA5 LSB first in cycles 27-34 -> frame 2 header bits = 1,1,1; SS_n low through cycle 34; rd_valid, done and rd_data = 0xA5 in cycle 35.
REQ-034: TURN_CYC = 0 read -> first MISO sample in the cycle immediately after frame 2 bit10; rd_valid in cycle 33.
REQ-035: rst pulse during SHIFT2 of a write -> SS_n = 1 within the same cycle, no done pulse, req_ready = 1 after release, and the next request runs normally.
REQ-036: req_valid held high with changing req_addr during a transaction -> no second acceptance; frame payloads match the values latched at acceptance.

Source files
------------

// File: rtl/spi_master_seq.sv
// spi_master_seq: memory-style SPI master issuing two 11-bit frames per request,
// with an optional turnaround and 8-bit MISO capture for reads.
module spi_master_seq #(
  parameter int GAP_CYC  = 2,
  parameter int TURN_CYC = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic       req_rw,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       req_ready,
  output logic       done,
  output logic       rd_valid,
  output logic [7:0] rd_data,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO
);
  typedef enum logic [2:0] {IDLE, SHIFT1, GAP1, SHIFT2, TURN, CAPTURE, GAP2} state_t;
  localparam logic [3:0] GAP_LAST  = 4'(GAP_CYC - 1);
  localparam logic [3:0] TURN_LAST = 4'(TURN_CYC - 1);
  state_t state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d, gap_cnt_q, gap_cnt_d;
  logic rw_q, rw_d, ready_q, ready_d, done_q, done_d, rd_valid_q, rd_valid_d;
  logic ss_n_q, ss_n_d, mosi_q, mosi_d, acc, stay;
  logic [7:0] addr_q, addr_d, wdata_q, wdata_d, cap_q, cap_d, rd_data_q, rd_data_d;
  logic [10:0] f1, f2;
  always_comb begin
    acc = req_valid & ready_q;
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = acc ? SHIFT1 : IDLE;
      SHIFT1:  state_d = bit_cnt_q == 4'd10 ? GAP1 : SHIFT1;
      GAP1:    state_d = gap_cnt_q == GAP_LAST ? SHIFT2 : GAP1;
      SHIFT2:  state_d = bit_cnt_q != 4'd10 ? SHIFT2 : !rw_q ? GAP2 : TURN_CYC == 0 ? CAPTURE : TURN;
      TURN:    state_d = gap_cnt_q == TURN_LAST ? CAPTURE : TURN;
      CAPTURE: state_d = bit_cnt_q == 4'd7 ? GAP2 : CAPTURE;
      GAP2:    state_d = gap_cnt_q == GAP_LAST ? IDLE : GAP2;
      default: state_d = IDLE;
    endcase
    stay = state_d == state_q;
    bit_cnt_d = stay && state_q inside {SHIFT1, SHIFT2, CAPTURE} ? bit_cnt_q + 4'd1 : 4'd0;
    gap_cnt_d = stay && state_q inside {GAP1, TURN, GAP2} ? gap_cnt_q + 4'd1 : 4'd0;
    rw_d    = acc ? req_rw : rw_q;
    addr_d  = acc ? req_addr : addr_q;
    wdata_d = acc ? req_wdata : wdata_q;
    // frame layout {payload, cmd[1], cmd[0], cmd[1]} so bit index equals wire order
    f1 = {addr_d, rw_d, 1'b0, rw_d};
    f2 = {rw_q ? 8'h00 : wdata_q, rw_q, 1'b1, rw_q};
    mosi_d = state_d == SHIFT1 ? f1[bit_cnt_d] : state_d == SHIFT2 ? f2[bit_cnt_d] : 1'b0;
    ss_n_d = state_d inside {IDLE, GAP1, GAP2};
    ready_d = state_d == IDLE;
    done_d = state_d == GAP2 && state_q != GAP2;
    rd_valid_d = state_q == CAPTURE && state_d == GAP2;
    cap_d = state_q == CAPTURE ? {MISO, cap_q[7:1]} : cap_q;
    rd_data_d = rd_valid_d ? cap_d : rd_data_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      rw_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      cap_q <= '0;
      rd_data_q <= '0;
      ready_q <= 1'b0;
      done_q <= 1'b0;
      rd_valid_q <= 1'b0;
      ss_n_q <= 1'b1;
      mosi_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      rw_q <= rw_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      cap_q <= cap_d;
      rd_data_q <= rd_data_d;
      ready_q <= ready_d;
      done_q <= done_d;
      rd_valid_q <= rd_valid_d;
      ss_n_q <= ss_n_d;
      mosi_q <= mosi_d;
    end
  end
  assign req_ready = ready_q;
  assign done = done_q;
  assign rd_valid = rd_valid_q;
  assign rd_data = rd_data_q;
  assign SS_n = ss_n_q;
  assign MOSI = mosi_q;
endmodule

// File: tb/tb_spi_master_seq.sv
// tb_spi_master_seq: randomized check of two spi_master_seq instances (GAP2/TURN2 and GAP3/TURN0)
// against a cycle-list model built from the frame rules.
module tb_spi_master_seq;
  logic clk = 1'b0, rst = 1'b1, req_valid = 1'b0, req_rw = 1'b0, miso = 1'b0, sel = 1'b0;
  logic [7:0] req_addr = '0, req_wdata = '0;
  logic rdy_a, done_a, rv_a, ss_a, mo_a, rdy_b, done_b, rv_b, ss_b, mo_b;
  logic [7:0] rd_a, rd_b;
  int tests = 0, fails = 0;
  logic [7:0] last_rd [2];
  typedef struct {logic ss; logic mo; logic dn; logic rv; logic mi;} cyc_t;
  cyc_t q[$];

  always #5 clk = ~clk;

  spi_master_seq #(.GAP_CYC(2), .TURN_CYC(2)) dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid & ~sel), .req_rw(req_rw), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(rdy_a), .done(done_a), .rd_valid(rv_a), .rd_data(rd_a),
    .SS_n(ss_a), .MOSI(mo_a), .MISO(miso));
  spi_master_seq #(.GAP_CYC(3), .TURN_CYC(0)) dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid & sel), .req_rw(req_rw), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(rdy_b), .done(done_b), .rd_valid(rv_b), .rd_data(rd_b),
    .SS_n(ss_b), .MOSI(mo_b), .MISO(miso));

  wire o_rdy = sel ? rdy_b : rdy_a;
  wire o_done = sel ? done_b : done_a;
  wire o_rv = sel ? rv_b : rv_a;
  wire o_ss = sel ? ss_b : ss_a;
  wire o_mo = sel ? mo_b : mo_a;
  wire [7:0] o_rd = sel ? rd_b : rd_a;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic push(input logic ss, input logic mo, input logic dn, input logic rv, input logic mi);
    q.push_back('{ss: ss, mo: mo, dn: dn, rv: rv, mi: mi});
  endtask

  task automatic frame(input logic c1, input logic c0, input logic [7:0] p);
    push(0, c1, 0, 0, 0);
    push(0, c0, 0, 0, 0);
    push(0, c1, 0, 0, 0);
    for (int i = 0; i < 8; i++) push(0, p[i], 0, 0, 0);
  endtask

  task automatic build(input logic rw, input logic [7:0] a, input logic [7:0] w, input logic [7:0] r,
                       input int g, input int t);
    q.delete();
    frame(rw, 1'b0, a);
    for (int i = 0; i < g; i++) push(1, 0, 0, 0, 0);
    frame(rw, 1'b1, rw ? 8'h00 : w);
    if (rw) begin
      for (int i = 0; i < t; i++) push(0, 0, 0, 0, 0);
      for (int i = 0; i < 8; i++) push(0, 0, 0, 0, r[i]);
    end
    for (int i = 0; i < g; i++) push(1, 0, i == 0, rw && i == 0, 0);
  endtask

  // abort > 0 pulses rst in that cycle of the transaction instead of completing it
  task automatic run(input logic s, input logic rw, input logic [7:0] a, input logic [7:0] w,
                     input logic [7:0] r, input bit hold, input int abort);
    sel = s;
    build(rw, a, w, r, s ? 3 : 2, s ? 0 : 2);
    @(negedge clk);
    chk("ready_idle", o_rdy, 1);
    req_valid = 1; req_rw = rw; req_addr = a; req_wdata = w;
    for (int k = 0; k < q.size(); k++) begin
      @(negedge clk);
      if (k + 1 == abort) begin
        rst = 1;
        #1;
        chk("abort_ss", o_ss, 1);
        chk("abort_done", o_done, 0);
        req_valid = 0;
        @(negedge clk);
        chk("abort_rdy", o_rdy, 0);
        chk("abort_rd", o_rd, 0);
        chk("abort_mosi", o_mo, 0);
        rst = 0;
        last_rd[0] = 0; last_rd[1] = 0;
        @(negedge clk);
        chk("abort_rel_rdy", o_rdy, 1);
        chk("abort_rel_done", o_done, 0);
        chk("abort_rel_ss", o_ss, 1);
        return;
      end
      chk("ss_n", o_ss, q[k].ss);
      chk("mosi", o_mo, q[k].mo);
      chk("done", o_done, q[k].dn);
      chk("rd_valid", o_rv, q[k].rv);
      chk("ready_busy", o_rdy, 0);
      if (q[k].dn) begin
        if (rw) last_rd[s] = r;
        chk("rd_data", o_rd, last_rd[s]);
      end
      miso = q[k].mi;
      if (hold) begin
        req_rw = 1'($urandom); req_addr = 8'($urandom); req_wdata = 8'($urandom);
      end else req_valid = 0;
    end
    @(negedge clk);
    req_valid = 0;
    chk("ready_after", o_rdy, 1);
    chk("ss_after", o_ss, 1);
  endtask

  initial begin
    last_rd[0] = 0; last_rd[1] = 0;
    repeat (2) @(negedge clk);
    chk("rst_ss", ss_a, 1); chk("rst_mosi", mo_a, 0); chk("rst_rdy", rdy_a, 0);
    chk("rst_done", done_a, 0); chk("rst_rv", rv_a, 0); chk("rst_rd", rd_a, 0);
    chk("rst_rdy_b", rdy_b, 0); chk("rst_ss_b", ss_b, 1);
    rst = 0;
    #1 chk("rdy_not_yet", rdy_a, 0);
    run(0, 0, 8'h5A, 8'hC3, 8'h00, 0, 0);
    run(0, 1, 8'h0F, 8'h00, 8'hA5, 0, 0);
    run(1, 1, 8'h3C, 8'h00, 8'h96, 0, 0);
    run(0, 0, 8'h81, 8'h7E, 8'h00, 1, 0);
    run(0, 0, 8'h22, 8'h44, 8'h00, 0, 18);
    run(0, 0, 8'h5A, 8'hC3, 8'h00, 0, 0);
    for (int n = 0; n < 24; n++)
      run(1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
